// File: rtl/bus_uart_pkg.sv
// Shared types and register-map constants for the memory-mapped UART transmitter.
package bus_uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  localparam logic [1:0] REG_TXDATA  = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_CONTROL = 2'd2;

  localparam int STAT_FULL  = 0;
  localparam int STAT_EMPTY = 1;
  localparam int STAT_BUSY  = 2;
  localparam int STAT_OVF   = 3;

  localparam int CTRL_IRQ_EN = 0;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational head output; pushes when full are discarded.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  // Acceptance is judged on the pre-edge count, so a pop never frees room for a same-cycle push.
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/bus_uart_tx.sv
// 6502-bus UART transmitter: register decode, overflow/irq control and an 8N1 TX state machine.
module bus_uart_tx
  import bus_uart_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR    = 16'hD000,
  parameter int          CLKS_PER_BIT = 868,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] address,
  input  logic        read_write,
  input  logic [7:0]  data_write,
  output logic        sel,
  output logic [7:0]  data_read,
  output logic        tx,
  output logic        irq
);

  localparam int              BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LOAD = BAUD_W'(CLKS_PER_BIT - 1);

  logic [1:0]  offset;
  logic        wr_stb, push, pop;
  logic [7:0]  fifo_dout;
  logic        fifo_full, fifo_empty;
  logic        ovf_q, ovf_d, irq_en_q, irq_en_d, irq_q, irq_d;
  logic        busy;

  tx_state_e         state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;

  assign offset = address[1:0];
  assign sel    = (address[15:2] == BASE_ADDR[15:2]);
  assign wr_stb = sel & ~read_write;
  assign push   = wr_stb & (offset == REG_TXDATA);

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst),
    .push  (push),
    .pop   (pop),
    .din   (data_write),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    data_read = 8'h00;
    if (sel) begin
      case (offset)
        REG_STATUS: begin
          data_read[STAT_FULL]  = fifo_full;
          data_read[STAT_EMPTY] = fifo_empty;
          data_read[STAT_BUSY]  = busy;
          data_read[STAT_OVF]   = ovf_q;
        end
        REG_CONTROL: data_read[CTRL_IRQ_EN] = irq_en_q;
        default:     data_read = 8'h00;
      endcase
    end
  end

  // A dropped push in the same cycle as a clear request leaves overflow set.
  always_comb begin
    ovf_d = ovf_q;
    if (wr_stb && (offset == REG_STATUS) && data_write[STAT_OVF]) ovf_d = 1'b0;
    if (push && fifo_full) ovf_d = 1'b1;
    irq_en_d = irq_en_q;
    if (wr_stb && (offset == REG_CONTROL)) irq_en_d = data_write[CTRL_IRQ_EN];
    irq_d = irq_en_q & fifo_empty & ~busy;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_q    <= 1'b0;
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      ovf_q    <= ovf_d;
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
    end
  end

  assign irq = irq_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
    end
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

  // STOP's final cycle reloads straight into START so queued frames abut with no idle gap.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_dout;
          baud_d  = BAUD_LOAD;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (baud_q == '0) begin
          state_d = ST_DATA;
          bit_d   = 3'd0;
          baud_d  = BAUD_LOAD;
        end else begin
          baud_d = baud_q - BAUD_W'(1);
        end
      end
      ST_DATA: begin
        if (baud_q == '0) begin
          baud_d  = BAUD_LOAD;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) state_d = ST_STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          baud_d = baud_q - BAUD_W'(1);
        end
      end
      ST_STOP: begin
        if (baud_q == '0) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_dout;
            baud_d  = BAUD_LOAD;
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          baud_d = baud_q - BAUD_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != ST_IDLE);
    case (state_q)
      ST_START: tx = 1'b0;
      ST_DATA:  tx = shift_q[0];
      default:  tx = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_bus_uart_tx.sv
// Directed bench for bus_uart_tx at 4 clocks per bit with an 8-entry FIFO.
module tb_bus_uart_tx;

  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] address = 16'h0000;
  logic        read_write = 1'b1;
  logic [7:0]  data_write = 8'h00;
  logic        sel;
  logic [7:0]  data_read;
  logic        tx;
  logic        irq;

  int          n_vec = 0;
  int          n_err = 0;
  int          frame_err = 0;
  logic [7:0]  rx_q[$];
  logic [7:0]  burst_buf[16];

  bus_uart_tx #(
    .BASE_ADDR    (16'hD000),
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .address    (address),
    .read_write (read_write),
    .data_write (data_write),
    .sel        (sel),
    .data_read  (data_read),
    .tx         (tx),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Receiver model: samples each bit in its middle cycle, records bytes in rx_q.
  initial begin
    logic [7:0] mb;
    logic       mstop;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && tx === 1'b0) begin
        repeat (CPB / 2) @(negedge clk);
        for (int j = 0; j < 8; j++) begin
          repeat (CPB) @(negedge clk);
          mb[j] = tx;
        end
        repeat (CPB) @(negedge clk);
        mstop = tx;
        repeat (CPB / 2 - 1) @(negedge clk);
        rx_q.push_back(mb);
        if (mstop !== 1'b1) frame_err++;
      end
    end
  end

  function automatic logic frame_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx == 9) return 1'b1;
    return b[idx-1];
  endfunction

  task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    address = a; read_write = 1'b0; data_write = d;
    @(negedge clk);
    read_write = 1'b1; address = 16'h0000;
  endtask

  // Writes burst_buf[0..n-1] to TXDATA on consecutive edges, then leaves STATUS addressed.
  task automatic burst_write(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      address = 16'hD000; read_write = 1'b0; data_write = burst_buf[i];
    end
    @(negedge clk);
    read_write = 1'b1; address = 16'hD001;
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    address = 16'hD001;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_vec++; if (tx !== 1'b1) begin n_err++; $display("FAIL reset_tx: got %b want 1", tx); end
      n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL reset_irq: got %b want 0", irq); end
    end
    #1;
    n_vec++; if (sel !== 1'b1) begin n_err++; $display("FAIL reset_sel: got %b want 1", sel); end
    n_vec++; if (data_read !== 8'h02) begin n_err++; $display("FAIL reset_status: got %h want 02", data_read); end
    address = 16'hD000; #1;
    n_vec++; if (data_read !== 8'h00) begin n_err++; $display("FAIL txdata_read: got %h want 00", data_read); end
    address = 16'hD003; #1;
    n_vec++; if (data_read !== 8'h00) begin n_err++; $display("FAIL reserved_read: got %h want 00", data_read); end
    address = 16'hD005; #1;
    n_vec++; if (sel !== 1'b0) begin n_err++; $display("FAIL sel_outside: got %b want 0", sel); end
    address = 16'h1001; #1;
    n_vec++; if (data_read !== 8'h00) begin n_err++; $display("FAIL read_outside: got %h want 00", data_read); end
    @(negedge clk);
    rst = 1'b1; address = 16'h0000;
    @(negedge clk);
  endtask

  task automatic test_frame_a5;
    rx_q.delete();
    bus_write(16'hD000, 8'hA5);
    n_vec++; if (tx !== 1'b1) begin n_err++; $display("FAIL a5_pre_start: got %b want 1", tx); end
    for (int i = 0; i < 10 * CPB; i++) begin
      @(negedge clk);
      n_vec++;
      if (tx !== frame_bit(8'hA5, i / CPB)) begin
        n_err++; $display("FAIL a5_tx[%0d]: got %b want %b", i, tx, frame_bit(8'hA5, i / CPB));
      end
    end
    @(negedge clk);
    address = 16'hD001; #1;
    n_vec++; if (data_read !== 8'h02) begin n_err++; $display("FAIL a5_status_after: got %h want 02", data_read); end
    n_vec++; if (tx !== 1'b1) begin n_err++; $display("FAIL a5_idle_tx: got %b want 1", tx); end
    n_vec++; if (rx_q.size() !== 1) begin n_err++; $display("FAIL a5_rx_count: got %0d want 1", rx_q.size()); end
    else begin
      n_vec++; if (rx_q[0] !== 8'hA5) begin n_err++; $display("FAIL a5_rx_byte: got %h want a5", rx_q[0]); end
    end
    address = 16'h0000;
  endtask

  task automatic test_back_to_back;
    int n;
    logic [7:0] exp_b[3];
    exp_b = '{8'h3C, 8'hFF, 8'h00};
    rx_q.delete();
    for (int i = 0; i < 3; i++) burst_buf[i] = exp_b[i];
    burst_write(3);
    n = 0;
    while (data_read[2] === 1'b1 && n < 300) begin
      n++;
      @(negedge clk); #1;
    end
    // Busy is first sampled two edges after the first write; the frames end 120 cycles after START.
    n_vec++; if (n !== 30 * CPB - 1) begin n_err++; $display("FAIL b2b_busy_cycles: got %0d want %0d", n, 30 * CPB - 1); end
    n_vec++; if (data_read !== 8'h02) begin n_err++; $display("FAIL b2b_status_after: got %h want 02", data_read); end
    n_vec++; if (rx_q.size() !== 3) begin n_err++; $display("FAIL b2b_rx_count: got %0d want 3", rx_q.size()); end
    else begin
      for (int i = 0; i < 3; i++) begin
        n_vec++; if (rx_q[i] !== exp_b[i]) begin n_err++; $display("FAIL b2b_rx[%0d]: got %h want %h", i, rx_q[i], exp_b[i]); end
      end
    end
    address = 16'h0000;
  endtask

  task automatic test_overflow;
    int n;
    rx_q.delete();
    burst_buf[0] = 8'h11;
    for (int i = 1; i < 9; i++) burst_buf[i] = 8'h20 + 8'(i);
    burst_buf[9] = 8'hEE;
    burst_write(10);
    n_vec++; if (data_read !== 8'h0D) begin n_err++; $display("FAIL ovf_status: got %h want 0d", data_read); end
    bus_write(16'hD001, 8'h08);
    address = 16'hD001; #1;
    n_vec++; if (data_read !== 8'h05) begin n_err++; $display("FAIL ovf_clear: got %h want 05", data_read); end
    n = 0;
    while (data_read[2] === 1'b1 && n < 600) begin
      n++;
      @(negedge clk); #1;
    end
    n_vec++; if (n >= 600) begin n_err++; $display("FAIL ovf_drain_timeout: got %0d cycles want <600", n); end
    n_vec++; if (data_read !== 8'h02) begin n_err++; $display("FAIL ovf_status_after: got %h want 02", data_read); end
    n_vec++; if (rx_q.size() !== 9) begin n_err++; $display("FAIL ovf_rx_count: got %0d want 9", rx_q.size()); end
    else begin
      for (int i = 0; i < 9; i++) begin
        n_vec++; if (rx_q[i] !== burst_buf[i]) begin n_err++; $display("FAIL ovf_rx[%0d]: got %h want %h", i, rx_q[i], burst_buf[i]); end
      end
    end
    address = 16'h0000;
  endtask

  task automatic test_irq;
    int n;
    rx_q.delete();
    bus_write(16'hD002, 8'h01);
    n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL irq_same_edge: got %b want 0", irq); end
    @(negedge clk);
    n_vec++; if (irq !== 1'b1) begin n_err++; $display("FAIL irq_assert: got %b want 1", irq); end
    address = 16'hD002; #1;
    n_vec++; if (data_read !== 8'h01) begin n_err++; $display("FAIL irq_ctrl_read: got %h want 01", data_read); end
    bus_write(16'hD000, 8'h5A);
    n_vec++; if (irq !== 1'b1) begin n_err++; $display("FAIL irq_push_edge: got %b want 1", irq); end
    @(negedge clk);
    n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL irq_drop: got %b want 0", irq); end
    n = 0;
    while (irq !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    n_vec++; if (n !== 10 * CPB + 1) begin n_err++; $display("FAIL irq_return_cycles: got %0d want %0d", n, 10 * CPB + 1); end
    n_vec++; if (rx_q.size() !== 1 || rx_q[0] !== 8'h5A) begin n_err++; $display("FAIL irq_rx: got %0d bytes want one 5a", rx_q.size()); end
    bus_write(16'hD002, 8'h00);
    @(negedge clk);
    n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL irq_disable: got %b want 0", irq); end
  endtask

  task automatic test_reset_midframe;
    int lows;
    for (int i = 0; i < 4; i++) burst_buf[i] = 8'h00;
    burst_write(4);
    repeat (10) @(negedge clk);
    n_vec++; if (tx !== 1'b0) begin n_err++; $display("FAIL mid_data_tx: got %b want 0", tx); end
    #2 rst = 1'b0;
    #1;
    n_vec++; if (tx !== 1'b1) begin n_err++; $display("FAIL async_reset_tx: got %b want 1", tx); end
    n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL async_reset_irq: got %b want 0", irq); end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    n_vec++; if (data_read !== 8'h02) begin n_err++; $display("FAIL post_reset_status: got %h want 02", data_read); end
    address = 16'hD002; #1;
    n_vec++; if (data_read !== 8'h00) begin n_err++; $display("FAIL post_reset_ctrl: got %h want 00", data_read); end
    lows = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    n_vec++; if (lows !== 0) begin n_err++; $display("FAIL post_reset_frames: got %0d low cycles want 0", lows); end
    address = 16'h0000;
  endtask

  initial begin
    test_reset();
    test_frame_a5();
    test_back_to_back();
    test_overflow();
    test_irq();
    test_reset_midframe();
    n_vec++; if (frame_err !== 0) begin n_err++; $display("FAIL stop_bits: got %0d bad stop bits want 0", frame_err); end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
